// File: rtl/data_ram_resp.sv
// data_ram_resp: responder end of the CPU data-memory bus.
// Word-organised, byte-lane-writable RAM with a synchronous read and
// WAIT_CYCLES extra busy cycles per access. The bus has no ready, so
// stallreq_o holds the MEM stage frozen until the access completes.
// Optional build macro: DRAM_PERF_CNT_EN adds read/write commit counters.
//
// Handshake: a request is ce_i=1 with we_i/addr_i/data_i/sel_i stable.
// While ce_i=1 and the FSM is not in DONE, stallreq_o=1 and the requester
// must hold the request unchanged. In DONE stallreq_o=0, and the requester
// advances at the end of that cycle, capturing data_o. Dropping ce_i
// before DONE aborts the access with no side effects.
module data_ram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] data_o,
  output logic        stallreq_o,
`ifdef DRAM_PERF_CNT_EN
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
`endif
  output logic [1:0]  fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // First BUSY cycle loads this; the access commits when it reaches zero.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  commit;
  logic [DEPTH_LOG2-1:0] word;
  logic [31:0]           mem [DEPTH];
  logic                  unused_addr;

  // Upper address bits alias and the byte offset is ignored.
  assign word        = addr_i[DEPTH_LOG2+1:2];
  assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};
  assign fsm_state   = state;

  // The access happens on the edge that enters DONE; reset suppresses it.
  assign commit = rst && ce_i &&
                  (((state == IDLE) && NO_WAIT) || ((state == BUSY) && (cnt == 4'd0)));

  // Stall whenever a request is pending and not yet completing.
  assign stallreq_o = ce_i && (state != DONE);

  // Access sequencer: IDLE -> BUSY (wait) -> DONE -> IDLE, abort on ce_i drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ce_i) begin
            if (NO_WAIT) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (!ce_i) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Byte-lane write on the commit edge; sel_i[3] is the most significant lane.
  always_ff @(posedge clk) begin
    if (commit && we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_i[i]) begin
          mem[word][8*i +: 8] <= data_i[8*i +: 8];
        end
      end
    end
  end

  // Read data is presented only during DONE and is zero otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_o <= 32'd0;
    end else if (commit) begin
      data_o <= we_i ? 32'd0 : mem[word];
    end else if (state == DONE) begin
      data_o <= 32'd0;
    end
  end

`ifdef DRAM_PERF_CNT_EN
  // Commit counters; aborted accesses never reach a commit edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt_o <= 32'd0;
      wr_cnt_o <= 32'd0;
    end else if (commit) begin
      if (we_i) begin
        wr_cnt_o <= wr_cnt_o + 32'd1;
      end else begin
        rd_cnt_o <= rd_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
